// File: rtl/hazard_stall_unit_if.sv
// Pipeline hazard interface: OF/EX instruction view and the stall/flush controls.
// The pipeline (master) drives the stage contents; the hazard unit (slave) drives the controls.
interface hazard_stall_unit_if;
    logic [31:0] instruction_of;
    logic        valid_of;
    logic [31:0] instruction_e;
    logic        valid_e;
    logic        isBranchTaken_E;
    logic        ext_stall;

    logic        stall_pc;
    logic        stall_of;
    logic        bubble_e;
    logic        flush_if;
    logic        flush_of;
    logic [1:0]  hz_state;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output instruction_of, valid_of, instruction_e, valid_e,
               isBranchTaken_E, ext_stall,
        input  stall_pc, stall_of, bubble_e, flush_if, flush_of,
               hz_state, stall_cnt, flush_cnt
    );

    modport slave (
        input  instruction_of, valid_of, instruction_e, valid_e,
               isBranchTaken_E, ext_stall,
        output stall_pc, stall_of, bubble_e, flush_if, flush_of,
               hz_state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use stall and taken-branch flush control for the OF/EX pipeline boundary,
// with saturating event counters.
//
// state | meaning
// RUN   | no hazard seen last cycle
// STALL | last cycle held PC/OF and inserted a bubble for a load-use hazard
// FLUSH | last cycle squashed IF/OF for a taken branch; OF content is post-flush
module hazard_stall_unit (
    input logic             clk,
    input logic             rst,
    hazard_stall_unit_if.slave hif
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } hz_state_t;

    localparam logic [4:0] OP_LD  = 5'b01110;
    localparam logic [4:0] OP_ST  = 5'b01111;
    localparam logic [4:0] OP_RET = 5'b10100;
    localparam logic [3:0] REG_RA = 4'd15;

    hz_state_t   state;
    hz_state_t   state_next;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    logic [4:0]  of_op;
    logic        of_imm;
    logic [3:0]  of_rs1;
    logic [3:0]  of_rs2;
    logic [4:0]  e_op;
    logic [3:0]  e_rd;

    logic        reads_rs1;
    logic        reads_rs2;
    logic        reads_ra;
    logic        lu;
    logic        lu_eff;
    logic        bf;

    assign of_op  = hif.instruction_of[31:27];
    assign of_imm = hif.instruction_of[26];
    assign of_rs1 = hif.instruction_of[21:18];
    assign of_rs2 = hif.instruction_of[17:14];
    assign e_op   = hif.instruction_e[31:27];
    assign e_rd   = hif.instruction_e[25:22];

    // The rd field of OF, its low bits and the EX immediate side play no part in hazards.
    logic unused_bits;
    assign unused_bits = ^{hif.instruction_of[25:22], hif.instruction_of[13:0],
                           hif.instruction_e[26], hif.instruction_e[21:0]};

    // Store data (rd of st) is forwarded late, so st only depends on its address register.
    always_comb begin
        reads_rs1 = 1'b0;
        reads_rs2 = 1'b0;
        reads_ra  = 1'b0;
        if (of_op <= 5'd7)
            reads_rs1 = 1'b1;
        if ((of_op >= 5'd10) && (of_op <= 5'd12))
            reads_rs1 = 1'b1;
        if ((of_op == OP_LD) || (of_op == OP_ST))
            reads_rs1 = 1'b1;
        if ((of_op <= 5'd12) && !of_imm)
            reads_rs2 = 1'b1;
        if (of_op == OP_RET)
            reads_ra = 1'b1;
    end

    assign lu = hif.valid_e && hif.valid_of && (e_op == OP_LD) &&
                ((reads_rs1 && (of_rs1 == e_rd)) ||
                 (reads_rs2 && (of_rs2 == e_rd)) ||
                 (reads_ra  && (e_rd == REG_RA)));

    assign lu_eff = lu && (state != FLUSH);
    assign bf     = hif.valid_e && hif.isBranchTaken_E;

    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= state_next;
    end

    always_comb begin
        state_next   = state;
        hif.stall_pc = 1'b0;
        hif.stall_of = 1'b0;
        hif.bubble_e = 1'b0;
        hif.flush_if = 1'b0;
        hif.flush_of = 1'b0;
        if (!rst) begin
            if (hif.ext_stall) begin
                hif.stall_pc = 1'b1;
                hif.stall_of = 1'b1;
            end else if (bf) begin
                state_next   = FLUSH;
                hif.flush_if = 1'b1;
                hif.flush_of = 1'b1;
            end else if (lu_eff) begin
                state_next   = STALL;
                hif.stall_pc = 1'b1;
                hif.stall_of = 1'b1;
                hif.bubble_e = 1'b1;
            end else begin
                state_next   = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else if (!hif.ext_stall) begin
            if (bf) begin
                if (flush_cnt != 16'hFFFF)
                    flush_cnt <= flush_cnt + 16'd1;
            end else if (lu_eff) begin
                if (stall_cnt != 16'hFFFF)
                    stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    assign hif.hz_state  = state;
    assign hif.stall_cnt = stall_cnt;
    assign hif.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: decode cases, flush priority, external freeze,
// counter saturation and reset behaviour.
module tb_hazard_stall_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_stall_unit_if hif ();

    hazard_stall_unit dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_stall;
    logic [15:0] exp_flush;

    wire [4:0] ctrl = {hif.stall_pc, hif.stall_of, hif.bubble_e, hif.flush_if, hif.flush_of};

    localparam logic [4:0] C_NONE  = 5'b00000;
    localparam logic [4:0] C_STALL = 5'b11100;
    localparam logic [4:0] C_FLUSH = 5'b00011;
    localparam logic [4:0] C_EXT   = 5'b11000;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_CMP = 5'd8;
    localparam logic [4:0] OP_13  = 5'd13;
    localparam logic [4:0] OP_LD  = 5'd14;
    localparam logic [4:0] OP_ST  = 5'd15;
    localparam logic [4:0] OP_BEQ = 5'd16;
    localparam logic [4:0] OP_RET = 5'd20;

    typedef struct {
        logic [31:0] ex;
        logic        ve;
        logic [31:0] of;
        logic        vo;
        logic        lu;
    } vec_t;

    function automatic logic [31:0] ins(input logic [4:0] op, input logic imm,
                                        input logic [3:0] rd, input logic [3:0] rs1,
                                        input logic [3:0] rs2);
        return {op, imm, rd, rs1, rs2, 14'd0};
    endfunction

    task automatic drive(input logic [31:0] ex, input logic ve, input logic [31:0] of,
                         input logic vo, input logic bt, input logic es);
        hif.instruction_e   = ex;
        hif.valid_e         = ve;
        hif.instruction_of  = of;
        hif.valid_of        = vo;
        hif.isBranchTaken_E = bt;
        hif.ext_stall       = es;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(ins(OP_LD, 0, 3, 0, 0), 1, ins(OP_ADD, 0, 1, 3, 2), 1, 0, 0);
        #1;
        checks++;
        if (ctrl !== C_NONE) begin
            failures++; $display("FAIL reset_ctrl_lu got=%b want=%b", ctrl, C_NONE);
        end
        step();
        drive(ins(OP_BEQ, 0, 0, 0, 0), 1, ins(OP_ADD, 0, 1, 3, 2), 1, 1, 0);
        #1;
        checks++;
        if (ctrl !== C_NONE) begin
            failures++; $display("FAIL reset_ctrl_bf got=%b want=%b", ctrl, C_NONE);
        end
        step();
        checks++;
        if (hif.hz_state !== 2'b00 || hif.stall_cnt !== 16'd0 || hif.flush_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_regs got=%b/%h/%h want=00/0000/0000",
                     hif.hz_state, hif.stall_cnt, hif.flush_cnt);
        end
        rst = 1'b0;
        drive(32'd0, 0, 32'd0, 0, 0, 0);
        exp_stall = 16'd0;
        exp_flush = 16'd0;
        step();
    endtask

    task automatic test_load_use_decode();
        vec_t v[$];
        logic [4:0] want;
        v.push_back('{ins(OP_LD, 0, 3, 0, 0), 1, ins(OP_ADD, 0, 1, 3, 2), 1, 1});
        v.push_back('{ins(OP_LD, 0, 3, 0, 0), 1, ins(OP_ADD, 0, 1, 2, 3), 1, 1});
        v.push_back('{ins(OP_LD, 0, 3, 0, 0), 1, ins(OP_ADD, 1, 1, 2, 3), 1, 0});
        v.push_back('{ins(OP_LD, 0, 3, 0, 0), 1, ins(OP_ST, 0, 3, 4, 0), 1, 0});
        v.push_back('{ins(OP_LD, 0, 3, 0, 0), 1, ins(OP_ST, 0, 5, 3, 0), 1, 1});
        v.push_back('{ins(OP_LD, 0, 15, 0, 0), 1, ins(OP_RET, 0, 0, 0, 0), 1, 1});
        v.push_back('{ins(OP_LD, 0, 3, 0, 0), 1, ins(OP_RET, 0, 0, 3, 3), 1, 0});
        v.push_back('{ins(OP_LD, 0, 0, 0, 0), 1, ins(OP_ADD, 0, 1, 0, 2), 1, 1});
        v.push_back('{ins(OP_LD, 0, 3, 0, 0), 1, ins(OP_ADD, 0, 1, 3, 2), 0, 0});
        v.push_back('{ins(OP_LD, 0, 3, 0, 0), 0, ins(OP_ADD, 0, 1, 3, 2), 1, 0});
        v.push_back('{ins(OP_ADD, 0, 3, 0, 0), 1, ins(OP_ADD, 0, 1, 3, 2), 1, 0});
        v.push_back('{ins(OP_LD, 0, 3, 0, 0), 1, ins(OP_CMP, 0, 0, 3, 5), 1, 0});
        v.push_back('{ins(OP_LD, 0, 3, 0, 0), 1, ins(OP_CMP, 0, 0, 5, 3), 1, 1});
        v.push_back('{ins(OP_LD, 0, 3, 0, 0), 1, ins(OP_13, 0, 3, 3, 3), 1, 0});
        v.push_back('{ins(OP_LD, 0, 3, 0, 0), 1, ins(OP_LD, 0, 7, 3, 0), 1, 1});
        foreach (v[i]) begin
            drive(v[i].ex, v[i].ve, v[i].of, v[i].vo, 0, 0);
            want = v[i].lu ? C_STALL : C_NONE;
            #1;
            checks++;
            if (ctrl !== want) begin
                failures++; $display("FAIL decode_ctrl[%0d] got=%b want=%b", i, ctrl, want);
            end
            step();
            if (v[i].lu) exp_stall++;
            checks++;
            if (hif.hz_state !== (v[i].lu ? 2'b01 : 2'b00) || hif.stall_cnt !== exp_stall) begin
                failures++;
                $display("FAIL decode_regs[%0d] got=%b/%h want=%b/%h", i, hif.hz_state,
                         hif.stall_cnt, v[i].lu ? 2'b01 : 2'b00, exp_stall);
            end
        end
        drive(32'd0, 0, 32'd0, 0, 0, 0);
        step();
    endtask

    task automatic test_branch_flush();
        drive(ins(OP_BEQ, 0, 0, 0, 0), 1, ins(OP_ADD, 0, 1, 3, 2), 1, 1, 0);
        #1;
        checks++;
        if (ctrl !== C_FLUSH) begin
            failures++; $display("FAIL bf_ctrl got=%b want=%b", ctrl, C_FLUSH);
        end
        step();
        exp_flush++;
        checks++;
        if (hif.hz_state !== 2'b10 || hif.flush_cnt !== exp_flush) begin
            failures++;
            $display("FAIL bf_regs got=%b/%h want=10/%h", hif.hz_state, hif.flush_cnt, exp_flush);
        end
        // In FLUSH the OF contents are stale, so a would-be load-use must be ignored.
        drive(ins(OP_LD, 0, 3, 0, 0), 1, ins(OP_ADD, 0, 1, 3, 2), 1, 0, 0);
        #1;
        checks++;
        if (ctrl !== C_NONE) begin
            failures++; $display("FAIL flush_suppress_ctrl got=%b want=%b", ctrl, C_NONE);
        end
        step();
        checks++;
        if (hif.hz_state !== 2'b00 || hif.stall_cnt !== exp_stall) begin
            failures++;
            $display("FAIL flush_suppress_regs got=%b/%h want=00/%h", hif.hz_state,
                     hif.stall_cnt, exp_stall);
        end
        #1;
        checks++;
        if (ctrl !== C_STALL) begin
            failures++; $display("FAIL after_flush_ctrl got=%b want=%b", ctrl, C_STALL);
        end
        step();
        exp_stall++;
        checks++;
        if (hif.hz_state !== 2'b01 || hif.stall_cnt !== exp_stall) begin
            failures++;
            $display("FAIL after_flush_regs got=%b/%h want=01/%h", hif.hz_state,
                     hif.stall_cnt, exp_stall);
        end
        drive(ins(OP_LD, 0, 3, 0, 0), 1, ins(OP_ADD, 0, 1, 3, 2), 1, 1, 0);
        #1;
        checks++;
        if (ctrl !== C_FLUSH) begin
            failures++; $display("FAIL bf_priority_ctrl got=%b want=%b", ctrl, C_FLUSH);
        end
        step();
        exp_flush++;
        checks++;
        if (hif.hz_state !== 2'b10 || hif.flush_cnt !== exp_flush || hif.stall_cnt !== exp_stall) begin
            failures++;
            $display("FAIL bf_priority_regs got=%b/%h/%h want=10/%h/%h", hif.hz_state,
                     hif.flush_cnt, hif.stall_cnt, exp_flush, exp_stall);
        end
        drive(32'd0, 0, 32'd0, 0, 0, 0);
        step();
    endtask

    task automatic test_ext_stall();
        drive(ins(OP_LD, 0, 3, 0, 0), 1, ins(OP_ADD, 0, 1, 3, 2), 1, 0, 1);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (ctrl !== C_EXT) begin
                failures++; $display("FAIL ext_ctrl[%0d] got=%b want=%b", c, ctrl, C_EXT);
            end
            step();
            checks++;
            if (hif.hz_state !== 2'b00 || hif.stall_cnt !== exp_stall) begin
                failures++;
                $display("FAIL ext_hold[%0d] got=%b/%h want=00/%h", c, hif.hz_state,
                         hif.stall_cnt, exp_stall);
            end
        end
        hif.ext_stall = 1'b0;
        #1;
        checks++;
        if (ctrl !== C_STALL) begin
            failures++; $display("FAIL ext_release_ctrl got=%b want=%b", ctrl, C_STALL);
        end
        step();
        exp_stall++;
        checks++;
        if (hif.hz_state !== 2'b01 || hif.stall_cnt !== exp_stall) begin
            failures++;
            $display("FAIL ext_release_regs got=%b/%h want=01/%h", hif.hz_state,
                     hif.stall_cnt, exp_stall);
        end
        drive(ins(OP_BEQ, 0, 0, 0, 0), 1, ins(OP_ADD, 0, 1, 2, 2), 1, 1, 1);
        #1;
        checks++;
        if (ctrl !== C_EXT) begin
            failures++; $display("FAIL ext_bf_ctrl got=%b want=%b", ctrl, C_EXT);
        end
        step();
        checks++;
        if (hif.hz_state !== 2'b01 || hif.flush_cnt !== exp_flush) begin
            failures++;
            $display("FAIL ext_bf_hold got=%b/%h want=01/%h", hif.hz_state,
                     hif.flush_cnt, exp_flush);
        end
        drive(32'd0, 0, 32'd0, 0, 0, 0);
        step();
    endtask

    task automatic test_back_to_back();
        int stalls = 0;
        logic [31:0] ex_seq [5];
        logic        ve_seq [5];
        logic [31:0] of_seq [5];
        ex_seq[0] = ins(OP_LD, 0, 3, 0, 0);  ve_seq[0] = 1; of_seq[0] = ins(OP_ADD, 0, 1, 3, 2);
        ex_seq[1] = ins(OP_LD, 0, 3, 0, 0);  ve_seq[1] = 0; of_seq[1] = ins(OP_ADD, 0, 1, 3, 2);
        ex_seq[2] = ins(OP_ADD, 0, 1, 3, 2); ve_seq[2] = 1; of_seq[2] = ins(OP_LD, 0, 4, 6, 0);
        ex_seq[3] = ins(OP_LD, 0, 4, 6, 0);  ve_seq[3] = 1; of_seq[3] = ins(OP_SUB, 0, 5, 4, 4);
        ex_seq[4] = ins(OP_LD, 0, 4, 6, 0);  ve_seq[4] = 0; of_seq[4] = ins(OP_SUB, 0, 5, 4, 4);
        for (int c = 0; c < 5; c++) begin
            drive(ex_seq[c], ve_seq[c], of_seq[c], 1, 0, 0);
            #1;
            if (ctrl === C_STALL) stalls++;
            step();
        end
        exp_stall = exp_stall + 16'd2;
        checks++;
        if (stalls !== 2 || hif.stall_cnt !== exp_stall) begin
            failures++;
            $display("FAIL back_to_back got=%0d/%h want=2/%h", stalls, hif.stall_cnt, exp_stall);
        end
        drive(32'd0, 0, 32'd0, 0, 0, 0);
        step();
    endtask

    task automatic test_saturation_and_reset();
        int budget = 0;
        drive(ins(OP_LD, 0, 3, 0, 0), 1, ins(OP_ADD, 0, 1, 3, 2), 1, 0, 0);
        while (exp_stall != 16'hFFFF && budget < 70000) begin
            step();
            exp_stall++;
            budget++;
        end
        checks++;
        if (hif.stall_cnt !== 16'hFFFF) begin
            failures++; $display("FAIL sat_reach got=%h want=ffff", hif.stall_cnt);
        end
        #1;
        checks++;
        if (ctrl !== C_STALL) begin
            failures++; $display("FAIL sat_ctrl got=%b want=%b", ctrl, C_STALL);
        end
        step();
        checks++;
        if (hif.stall_cnt !== 16'hFFFF || hif.hz_state !== 2'b01) begin
            failures++;
            $display("FAIL sat_hold got=%h/%b want=ffff/01", hif.stall_cnt, hif.hz_state);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ctrl !== C_NONE) begin
            failures++; $display("FAIL rst_stall_ctrl got=%b want=%b", ctrl, C_NONE);
        end
        step();
        checks++;
        if (hif.hz_state !== 2'b00 || hif.stall_cnt !== 16'd0 || hif.flush_cnt !== 16'd0) begin
            failures++;
            $display("FAIL rst_stall_regs got=%b/%h/%h want=00/0000/0000",
                     hif.hz_state, hif.stall_cnt, hif.flush_cnt);
        end
        rst = 1'b0;
        drive(ins(OP_BEQ, 0, 0, 0, 0), 1, ins(OP_ADD, 0, 1, 3, 2), 1, 1, 0);
        step();
        checks++;
        if (hif.hz_state !== 2'b10 || hif.flush_cnt !== 16'd1) begin
            failures++;
            $display("FAIL pre_rst_flush got=%b/%h want=10/0001", hif.hz_state, hif.flush_cnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ctrl !== C_NONE) begin
            failures++; $display("FAIL rst_flush_ctrl got=%b want=%b", ctrl, C_NONE);
        end
        step();
        checks++;
        if (hif.hz_state !== 2'b00 || hif.flush_cnt !== 16'd0) begin
            failures++;
            $display("FAIL rst_flush_regs got=%b/%h want=00/0000", hif.hz_state, hif.flush_cnt);
        end
        rst = 1'b0;
        drive(32'd0, 0, 32'd0, 0, 0, 0);
        step();
    endtask

    initial begin
        test_reset();
        test_load_use_decode();
        test_branch_flush();
        test_ext_stall();
        test_back_to_back();
        test_saturation_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 clk  input  1  single pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 instruction_of  input  32  instruction in OF stage; opcode [31:27], I bit [26], rd [25:22], rs1 [21:18], rs2 [17:14].
REQ-004 valid_of  input  1  OF instruction is real (0 = bubble).
REQ-005 instruction_e  input  32  instruction in EX stage, same field layout.
REQ-006 valid_e  input  1  EX instruction is real.
REQ-007 isBranchTaken_E  input  1  branch/call/ret in EX resolved taken this cycle.
REQ-008 ext_stall  input  1  external freeze (multi-cycle mul/div or memory busy).
REQ-009 stall_pc  output  1  hold PC.
REQ-010 stall_of  output  1  hold IF/OF pipeline register.
REQ-011 bubble_e  output  1  load OF/EX register with nop (valid=0) at next edge.
REQ-012 flush_if  output  1  squash instruction in IF.
REQ-013 flush_of  output  1  squash instruction in OF.
REQ-014 hz_state  output  2  current FSM state: 00 RUN, 01 STALL, 10 FLUSH.
REQ-015 stall_cnt  output  16  saturating count of load-use stall cycles.
REQ-016 flush_cnt  output  16  saturating count of branch-flush events.

Function
REQ-017 Load-use hazard (lu) SHALL be: valid_e & valid_of & instruction_e[31:27]==01110 (ld) & OF reads instruction_e[25:22] per REQ-018.
REQ-018 OF reads rs1 for opcodes 00000-00111, 01010-01100, 01110, 01111; reads rs2 only when I=0 for opcodes 00000-00111, 01000, 01001, 01010-01100; ret (10100) reads register 15; store data field (rd of st) SHALL NOT cause lu (covered by RW->M forwarding).
REQ-019 Branch flush (bf) SHALL be valid_e & isBranchTaken_E.
REQ-020 Outputs combinational from current inputs, same cycle as condition: bf -> flush_if=1, flush_of=1, stall_pc=0, stall_of=0, bubble_e=0.
REQ-021 lu & !bf -> stall_pc=1, stall_of=1, bubble_e=1, flushes 0; bf SHALL have priority over lu.
REQ-022 ext_stall=1 -> stall_pc=1, stall_of=1, bubble_e=0, flush_if=flush_of=0, FSM and counters hold; bf/lu re-evaluated once ext_stall drops.
REQ-023 Neither condition -> all control outputs 0.
REQ-024 FSM next state (when ext_stall=0): bf -> FLUSH; else lu -> STALL; else RUN; from any state.
REQ-025 In FLUSH state, lu SHALL be suppressed (OF content is post-flush; valid_of assumed 0 but not relied upon).
REQ-026 stall_cnt SHALL increment by 1 per edge where lu & !bf & !ext_stall; saturate at 16'hFFFF.
REQ-027 flush_cnt SHALL increment by 1 per edge where bf & !ext_stall; saturate at 16'hFFFF.
REQ-028 Register 0 is an ordinary register; rd==0 matches are hazards.
REQ-029 Back-to-back ld->dependent: exactly one stall cycle per pair (ld leaves EX after bubble).

Reset
REQ-030 While rst=1: all control outputs 0, hz_state=00, stall_cnt=0, flush_cnt=0, regardless of other inputs.
REQ-031 rst asserted mid-stall or mid-flush SHALL return FSM to RUN at next edge; counters cleared same edge.

Verification
REQ-032 EX=ld r3 (valid), OF=add r1,r3,r2 (I=0, valid) -> stall_pc=stall_of=bubble_e=1, next hz_state=01, stall_cnt 0->1.
REQ-033 EX=ld r3, OF=st r3,[r4] (r3 is store data) -> no stall, all outputs 0; OF=st r5,[r3] -> stall.
REQ-034 EX=ld r3 with isBranchTaken_E=1 not possible; use EX=beq taken + OF=add r1,r3,r2 after ld -> flush_if=flush_of=1, stall 0, flush_cnt+1, hz_state=10.
REQ-035 lu present with ext_stall=1 for 3 cycles -> stall_pc=stall_of=1, bubble_e=0, stall_cnt unchanged; ext_stall drop -> bubble_e=1, stall_cnt+1.
REQ-036 stall_cnt preloaded to FFFF via 65535 stalls (or forced) -> further lu keeps FFFF; rst=1 during STALL -> outputs 0, hz_state=00, counters 0 next edge.
